// File: rtl/prng_sched.sv
// prng_sched: round-robin scheduler sharing one PRNG datapath between two
// requesters. A granted job loads seed/type into the PRNG, waits out a
// configurable warm-up delay, then streams N random words back.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   req[1:0]                      level job requests, held until grant
//   req_typ0/1, req_seed0/1       per-requester PRNG type and seed
//   req_cnt0/1                    draws per job (0 means 2^CNT_W)
//   cfg_delay                     warm-up cycles after seed load
//   gnt[1:0]                      one-hot 1-cycle grant pulse
//   prng_t_sel/typ_sel/t_dat      PRNG seed strobe, type, seed
//   prng_dat                      PRNG output word
//   rsp_vld/id/dat/last           response stream to the job owner
//   busy                          a job is in progress
//
// state | meaning
// IDLE  | waiting for a request, arbitrates and grants
// SEED  | one-cycle seed-load strobe to the PRNG
// WAIT  | PRNG warm-up, dly_cnt counts down to zero
// DRAW  | one response word per cycle until the draw count is exhausted
module prng_sched #(
  parameter int DAT_W = 16,
  parameter int TYP_W = 2,
  parameter int DLY_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [TYP_W-1:0] req_typ0,
  input  logic [TYP_W-1:0] req_typ1,
  input  logic [DAT_W-1:0] req_seed0,
  input  logic [DAT_W-1:0] req_seed1,
  input  logic [CNT_W-1:0] req_cnt0,
  input  logic [CNT_W-1:0] req_cnt1,
  input  logic [DLY_W-1:0] cfg_delay,
  output logic [1:0]       gnt,
  output logic             prng_t_sel,
  output logic [TYP_W-1:0] prng_typ_sel,
  output logic [DAT_W-1:0] prng_t_dat,
  input  logic [DAT_W-1:0] prng_dat,
  output logic             rsp_vld,
  output logic             rsp_id,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SEED, WAIT, DRAW} state_t;

  state_t           state, state_nxt;
  logic             id_q;
  logic             last_id;
  logic [TYP_W-1:0] typ_q;
  logic [DAT_W-1:0] seed_q;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] dly_cnt;
  logic [CNT_W:0]   rem;
  logic             grant;
  logic             win;
  logic [CNT_W-1:0] win_cnt;

  // With both requesting, the one after last_id wins; otherwise the sole requester.
  always_comb begin
    grant   = (state == IDLE) && (req != 2'b00);
    win     = (req == 2'b11) ? ~last_id : req[1];
    win_cnt = win ? req_cnt1 : req_cnt0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req != 2'b00) state_nxt = SEED;
      SEED: state_nxt = (dly_q == '0) ? DRAW : WAIT;
      WAIT: if (dly_cnt == DLY_W'(1)) state_nxt = DRAW;
      DRAW: if (rem == (CNT_W+1)'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prng_t_sel   = (state == SEED);
    busy         = (state != IDLE);
    prng_t_dat   = seed_q;
    prng_typ_sel = typ_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= 2'b00;
      id_q     <= 1'b0;
      last_id  <= 1'b1;
      typ_q    <= '0;
      seed_q   <= '0;
      dly_q    <= '0;
      dly_cnt  <= '0;
      rem      <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_dat  <= '0;
      rsp_last <= 1'b0;
    end else begin
      gnt      <= 2'b00;
      rsp_vld  <= 1'b0;
      rsp_last <= 1'b0;
      if (grant) begin
        gnt    <= win ? 2'b10 : 2'b01;
        id_q   <= win;
        typ_q  <= win ? req_typ1 : req_typ0;
        seed_q <= win ? req_seed1 : req_seed0;
        dly_q  <= cfg_delay;
        // A zero count requests the full 2^CNT_W words.
        rem    <= (win_cnt == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, win_cnt};
      end
      if (state == SEED) dly_cnt <= dly_q;
      if (state == WAIT) dly_cnt <= dly_cnt - DLY_W'(1);
      if (state == DRAW) begin
        rsp_vld <= 1'b1;
        rsp_dat <= prng_dat;
        rsp_id  <= id_q;
        rem     <= rem - (CNT_W+1)'(1);
        if (rem == (CNT_W+1)'(1)) begin
          rsp_last <= 1'b1;
          last_id  <= id_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_prng_sched.sv
module tb_prng_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_typ0, req_typ1;
  logic [15:0] req_seed0, req_seed1;
  logic [3:0]  req_cnt0, req_cnt1;
  logic [3:0]  cfg_delay;
  logic [1:0]  gnt;
  logic        prng_t_sel;
  logic [1:0]  prng_typ_sel;
  logic [15:0] prng_t_dat;
  logic [15:0] prng_dat;
  logic        rsp_vld, rsp_id, rsp_last, busy;
  logic [15:0] rsp_dat;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic exp_last;

  prng_sched dut (
    .clk(clk), .reset(reset), .req(req),
    .req_typ0(req_typ0), .req_typ1(req_typ1),
    .req_seed0(req_seed0), .req_seed1(req_seed1),
    .req_cnt0(req_cnt0), .req_cnt1(req_cnt1),
    .cfg_delay(cfg_delay), .gnt(gnt),
    .prng_t_sel(prng_t_sel), .prng_typ_sel(prng_typ_sel),
    .prng_t_dat(prng_t_dat), .prng_dat(prng_dat),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_dat(rsp_dat),
    .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in PRNG: Galois LFSR, output word mixed with the type select.
  function automatic logic [15:0] step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [15:0] lfsr = 16'h0001;
  always @(posedge clk) begin
    if (prng_t_sel) lfsr <= prng_t_dat;
    else            lfsr <= step(lfsr);
  end
  assign prng_dat = lfsr ^ {8{prng_typ_sel}};

  // Word k of a job: the seed advanced (delay + k) times, mixed with the type.
  function automatic logic [15:0] exp_word(input logic [15:0] seed, input logic [1:0] typ, input int idx);
    logic [15:0] x;
    x = seed;
    for (int i = 0; i < idx; i++) x = step(x);
    return x ^ {8{typ}};
  endfunction

  logic [1:0]  obs_gnt;
  int          obs_gnt_cyc;
  int          obs_tsel_cnt;
  logic [15:0] obs_tdat;
  int          obs_first_lat;
  logic [3:0]  obs_typ_seen;
  logic        obs_busy_end;
  bit          obs_timeout;
  logic [15:0] q_dat[$];
  logic        q_id[$];
  logic        q_last[$];

  // Waits for a grant, then records the job's observable behaviour (no checking).
  task automatic observe_job(input bit drop, input bit mutate, input int stop_after);
    int  n;
    bit  done;
    obs_gnt = 2'b00; obs_tsel_cnt = 0; obs_tdat = '0; obs_first_lat = -1;
    obs_typ_seen = '0; obs_busy_end = 1'bx; obs_timeout = 0;
    q_dat.delete(); q_id.delete(); q_last.delete();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 200);
    if (gnt == 2'b00) begin
      obs_timeout = 1;
      return;
    end
    obs_gnt = gnt;
    obs_gnt_cyc = cyc;
    if (drop) req = req & ~gnt;
    n = 0;
    done = 0;
    while (!done && n < 300) begin
      if (prng_t_sel) begin obs_tsel_cnt++; obs_tdat = prng_t_dat; end
      if (busy) obs_typ_seen[prng_typ_sel] = 1'b1;
      if (rsp_vld) begin
        if (obs_first_lat < 0) obs_first_lat = n;
        q_dat.push_back(rsp_dat); q_id.push_back(rsp_id); q_last.push_back(rsp_last);
        if (rsp_last || (stop_after > 0 && q_dat.size() == stop_after)) begin
          done = 1;
          obs_busy_end = busy;
        end
      end
      if (mutate && n == 2) begin
        req_seed0 = 16'($urandom);
        req_typ0  = 2'($urandom);
      end
      if (!done) begin @(negedge clk); n++; end
    end
    if (!done) obs_timeout = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00;
    req_typ0 = 0; req_typ1 = 0; req_seed0 = 0; req_seed1 = 0;
    req_cnt0 = 0; req_cnt1 = 0; cfg_delay = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({gnt, prng_t_sel, prng_typ_sel, prng_t_dat, rsp_vld, rsp_id, rsp_dat, rsp_last, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b tsel=%b typ=%0d tdat=%h vld=%b id=%b dat=%h last=%b busy=%b, expected all 0",
               gnt, prng_t_sel, prng_typ_sel, prng_t_dat, rsp_vld, rsp_id, rsp_dat, rsp_last, busy);
    end
    reset = 1'b0;
    exp_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_seed0 = 16'hACE1; req_typ0 = 2; req_cnt0 = 3; cfg_delay = 2;
    req_seed1 = 16'h1234; req_typ1 = 1; req_cnt1 = 7;
    req = 2'b01;
    observe_job(1, 0, 0);
    tests++;
    if (obs_timeout || obs_gnt !== 2'b01) begin fails++; $display("FAIL single_gnt: got %b timeout=%0d, expected 01", obs_gnt, obs_timeout); end
    tests++;
    if (obs_tsel_cnt != 1 || obs_tdat !== 16'hACE1) begin fails++; $display("FAIL single_seed: got tsel_cycles=%0d tdat=%h, expected 1 and ace1", obs_tsel_cnt, obs_tdat); end
    tests++;
    if (obs_first_lat != 4) begin fails++; $display("FAIL single_latency: got %0d, expected 4", obs_first_lat); end
    tests++;
    if (q_dat.size() != 3) begin fails++; $display("FAIL single_count: got %0d words, expected 3", q_dat.size()); end
    for (int k = 0; k < q_dat.size() && k < 3; k++) begin
      tests++;
      if (q_dat[k] !== exp_word(16'hACE1, 2, 2 + k) || q_id[k] !== 1'b0 || q_last[k] !== (k == 2)) begin
        fails++;
        $display("FAIL single_word%0d: got dat=%h id=%b last=%b, expected dat=%h id=0 last=%b",
                 k, q_dat[k], q_id[k], q_last[k], exp_word(16'hACE1, 2, 2 + k), k == 2);
      end
    end
    tests++;
    if (obs_busy_end !== 1'b0 || obs_typ_seen !== 4'b0100) begin fails++; $display("FAIL single_busy_typ: got busy=%b typ_seen=%b, expected 0 and 0100", obs_busy_end, obs_typ_seen); end
    exp_last = 1'b0;
  endtask

  task automatic test_contention();
    logic w;
    int   prev;
    req_seed0 = 16'h0F0F; req_typ0 = 1; req_seed1 = 16'h7777; req_typ1 = 3;
    req_cnt0 = 1; req_cnt1 = 1; cfg_delay = 0;
    req = 2'b11;
    prev = 0;
    for (int j = 0; j < 4; j++) begin
      w = ~exp_last;
      observe_job(0, 0, 0);
      if (j == 3) req = 2'b00;
      tests++;
      if (obs_timeout || obs_gnt !== (w ? 2'b10 : 2'b01)) begin fails++; $display("FAIL contention_gnt%0d: got %b, expected %b", j, obs_gnt, w ? 2'b10 : 2'b01); end
      tests++;
      if (q_dat.size() != 1 || q_dat[0] !== exp_word(w ? 16'h7777 : 16'h0F0F, w ? 2'd3 : 2'd1, 0) || q_id[0] !== w) begin
        fails++; $display("FAIL contention_word%0d: got n=%0d dat=%h, expected 1 word from id %0d", j, q_dat.size(), q_dat.size() > 0 ? q_dat[0] : 16'h0, w);
      end
      if (j > 0) begin
        tests++;
        if (obs_gnt_cyc - prev != 3) begin fails++; $display("FAIL contention_spacing%0d: got %0d cycles, expected 3", j, obs_gnt_cyc - prev); end
      end
      prev = obs_gnt_cyc;
      exp_last = w;
    end
  endtask

  task automatic test_cnt_zero();
    int nlast;
    req_seed1 = 16'hBEEF; req_typ1 = 0; req_cnt1 = 0; cfg_delay = 0;
    req = 2'b10;
    observe_job(1, 0, 0);
    tests++;
    if (obs_timeout || q_dat.size() != 16) begin fails++; $display("FAIL cnt0_count: got %0d words, expected 16", q_dat.size()); end
    nlast = 0;
    foreach (q_last[k]) if (q_last[k]) nlast++;
    tests++;
    if (nlast != 1 || q_last[q_last.size()-1] !== 1'b1) begin fails++; $display("FAIL cnt0_last: got %0d last flags, expected exactly 1 on word 16", nlast); end
    for (int k = 0; k < q_dat.size(); k++) begin
      tests++;
      if (q_dat[k] !== exp_word(16'hBEEF, 0, k)) begin fails++; $display("FAIL cnt0_word%0d: got %h, expected %h", k, q_dat[k], exp_word(16'hBEEF, 0, k)); end
    end
    exp_last = 1'b1;
  endtask

  task automatic test_long_delay();
    req_seed0 = 16'h5A5A; req_typ0 = 3; req_cnt0 = 1; cfg_delay = 15;
    req = 2'b01;
    observe_job(1, 0, 0);
    // first word 18 cycles after the grant cycle, i.e. 17 after gnt is visible
    tests++;
    if (obs_timeout || obs_first_lat != 17) begin fails++; $display("FAIL delay15_latency: got %0d, expected 17", obs_first_lat); end
    tests++;
    if (q_dat.size() != 1 || q_dat[0] !== exp_word(16'h5A5A, 3, 15)) begin fails++; $display("FAIL delay15_word: got n=%0d, expected 1 word %h", q_dat.size(), exp_word(16'h5A5A, 3, 15)); end
    exp_last = 1'b0;
  endtask

  task automatic test_random();
    logic        w;
    logic [15:0] s;
    logic [1:0]  t;
    int          n, d, bad;
    for (int j = 0; j < 8; j++) begin
      req_seed0 = 16'($urandom_range(1, 65535)); req_seed1 = 16'($urandom_range(1, 65535));
      req_typ0 = 2'($urandom); req_typ1 = 2'($urandom);
      req_cnt0 = 4'($urandom); req_cnt1 = 4'($urandom);
      cfg_delay = 4'($urandom_range(0, 5));
      req = 2'($urandom_range(1, 3));
      w = (req == 2'b11) ? ~exp_last : req[1];
      s = w ? req_seed1 : req_seed0;
      t = w ? req_typ1 : req_typ0;
      n = w ? req_cnt1 : req_cnt0;
      if (n == 0) n = 16;
      d = cfg_delay;
      observe_job(1, 0, 0);
      req = 2'b00;
      tests++;
      if (obs_timeout || obs_gnt !== (w ? 2'b10 : 2'b01) || q_dat.size() != n || obs_first_lat != 2 + d) begin
        fails++;
        $display("FAIL random%0d_job: got gnt=%b n=%0d lat=%0d, expected gnt=%b n=%0d lat=%0d",
                 j, obs_gnt, q_dat.size(), obs_first_lat, w ? 2'b10 : 2'b01, n, 2 + d);
      end
      bad = 0;
      for (int k = 0; k < q_dat.size(); k++)
        if (q_dat[k] !== exp_word(s, t, d + k) || q_id[k] !== w || q_last[k] !== (k == n - 1)) bad++;
      tests++;
      if (bad != 0) begin fails++; $display("FAIL random%0d_words: got %0d bad words, expected 0", j, bad); end
      exp_last = w;
      // a still-pending loser may be granted; let any such job finish
      repeat (40) @(negedge clk);
      if (gnt == 2'b00 && !busy) ; // idle here since req was cleared
    end
    // the loop clears req right after each job, so no extra job started
  endtask

  task automatic test_reset_mid();
    req_seed1 = 16'hC0DE; req_typ1 = 2; req_cnt1 = 5; cfg_delay = 1;
    req = 2'b10;
    observe_job(1, 0, 2);
    tests++;
    if (obs_timeout || q_dat.size() != 2) begin fails++; $display("FAIL rstmid_pre: got %0d words, expected 2 before reset", q_dat.size()); end
    reset = 1'b1;
    #1;
    tests++;
    if ({gnt, prng_t_sel, prng_typ_sel, prng_t_dat, rsp_vld, rsp_id, rsp_dat, rsp_last, busy} !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: got gnt=%b tsel=%b typ=%0d tdat=%h vld=%b id=%b dat=%h last=%b busy=%b, expected all 0",
               gnt, prng_t_sel, prng_typ_sel, prng_t_dat, rsp_vld, rsp_id, rsp_dat, rsp_last, busy);
    end
    req_seed0 = 16'h1111; req_typ0 = 1; req_cnt0 = 1; req_cnt1 = 1; cfg_delay = 0;
    req = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_last = 1'b1;
    observe_job(1, 0, 0);
    tests++;
    if (obs_timeout || obs_gnt !== 2'b01) begin fails++; $display("FAIL rstmid_prio: got %b, expected 01", obs_gnt); end
    exp_last = 1'b0;
    observe_job(1, 0, 0);
    req = 2'b00;
    tests++;
    if (obs_timeout || obs_gnt !== 2'b10 || q_dat.size() != 1) begin fails++; $display("FAIL rstmid_next: got gnt=%b n=%0d, expected 10 and 1", obs_gnt, q_dat.size()); end
    exp_last = 1'b1;
  endtask

  task automatic test_stability();
    req_seed0 = 16'h2468; req_typ0 = 1; req_cnt0 = 4; cfg_delay = 4;
    req = 2'b01;
    observe_job(1, 1, 0);
    tests++;
    if (obs_timeout || obs_typ_seen !== 4'b0010) begin fails++; $display("FAIL stable_typ: got typ_seen=%b, expected 0010", obs_typ_seen); end
    tests++;
    if (q_dat.size() != 4) begin fails++; $display("FAIL stable_count: got %0d, expected 4", q_dat.size()); end
    for (int k = 0; k < q_dat.size(); k++) begin
      tests++;
      if (q_dat[k] !== exp_word(16'h2468, 1, 4 + k)) begin fails++; $display("FAIL stable_word%0d: got %h, expected %h", k, q_dat[k], exp_word(16'h2468, 1, 4 + k)); end
    end
    exp_last = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_cnt_zero();
    test_long_delay();
    test_random();
    test_reset_mid();
    test_stability();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
